// File: rtl/pwm_fifo_writer_pkg.sv
// Shared defaults and FSM encodings for the PWM gate FIFO writer.
package pwm_fifo_writer_pkg;

  localparam int DEF_REF_W        = 16;
  localparam int DEF_CNT_W        = 16;
  localparam int DEF_CARRIER_PEAK = 1000;
  localparam int DEF_PRIME_DEPTH  = 4;
  localparam int DEF_FIFO_DEPTH   = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

endpackage

// File: rtl/pwm_tri_carrier.sv
// Triangular carrier 0..CARRIER_PEAK with reflect-at-apex/zero arithmetic.
// carrier_next/reflect describe the step currently being applied when advance is high.
module pwm_tri_carrier
  import pwm_fifo_writer_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int CARRIER_PEAK = DEF_CARRIER_PEAK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic [CNT_W-1:0] inc,
  output logic [CNT_W:0]   carrier_next,
  output logic             reflect
);

  typedef logic [CNT_W:0] ext_t;

  localparam ext_t PEAK_X  = ext_t'(CARRIER_PEAK);
  localparam ext_t PEAK2_X = ext_t'(2 * CARRIER_PEAK);

  function automatic ext_t clamp_inc(input logic [CNT_W-1:0] v);
    ext_t vx;
    vx = {1'b0, v};
    return (vx > PEAK_X) ? PEAK_X : vx;
  endfunction

  logic [CNT_W-1:0] carrier;
  logic             dir_down;
  logic             dir_down_next;
  ext_t             carrier_x;
  ext_t             inc_x;
  ext_t             sum_x;
  ext_t             next_x;

  // One extra bit keeps c+inc and 2*PEAK-(c+inc) free of wrap.
  always_comb begin
    carrier_x     = {1'b0, carrier};
    inc_x         = clamp_inc(inc);
    sum_x         = carrier_x + inc_x;
    next_x        = sum_x;
    dir_down_next = dir_down;
    if (!dir_down) begin
      if (sum_x >= PEAK_X) begin
        next_x        = PEAK2_X - sum_x;
        dir_down_next = 1'b1;
      end
    end else if (inc_x >= carrier_x) begin
      next_x        = inc_x - carrier_x;
      dir_down_next = 1'b0;
    end else begin
      next_x = carrier_x - inc_x;
    end
  end

  assign carrier_next = next_x;
  assign reflect      = dir_down_next ^ dir_down;

  always_ff @(posedge clk) begin
    if (rst) begin
      carrier  <= '0;
      dir_down <= 1'b0;
    end else if (advance) begin
      carrier  <= next_x[CNT_W-1:0];
      dir_down <= dir_down_next;
    end
  end

endmodule

// File: rtl/pwm_fifo_writer.sv
// Per-step PWM gate producer: carrier compare, FIFO write gating, priming and rd_start.
// Optional regular (reflect-latched) sampling via PWM_FIFO_WRITER_REGULAR_SAMPLE_EN.
module pwm_fifo_writer
  import pwm_fifo_writer_pkg::*;
#(
  parameter int REF_W        = DEF_REF_W,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int CARRIER_PEAK = DEF_CARRIER_PEAK,
  parameter int PRIME_DEPTH  = DEF_PRIME_DEPTH,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rst_user,
  input  logic                    step_in,
  input  logic signed [REF_W-1:0] ref_in,
  input  logic [CNT_W-1:0]        carrier_inc,
  input  logic [3:0]              usedw,
  input  logic                    full,
  output logic                    pwm_bit,
  output logic                    wr_en,
  output logic                    rd_start,
  output logic                    primed,
  output logic                    overflow_err
);

  typedef logic [CNT_W:0] ext_t;

  localparam ext_t       PEAK_X      = ext_t'(CARRIER_PEAK);
  localparam logic [4:0] USEDW_LIMIT = 5'(FIFO_DEPTH - 1);
  localparam logic [3:0] PRIME_LAST  = 4'(PRIME_DEPTH - 1);

  function automatic ext_t clamp_ref(input logic signed [REF_W-1:0] r);
    int rv;
    rv = int'(r);
    if (rv < 0) return '0;
    if (rv > CARRIER_PEAK) return PEAK_X;
    return ext_t'(rv);
  endfunction

  logic                    any_rst;
  logic                    vld_p0;
  logic signed [REF_W-1:0] ref_p0;
  logic [CNT_W-1:0]        inc_p0;
  logic [1:0]              state;
  logic [3:0]              prime_cnt;
  ext_t                    carrier_next;
  logic                    reflect;
  ext_t                    ref_clamped;
  ext_t                    cmp_ref;
  logic                    cmp_bit;
  logic                    wr_ok;

  assign any_rst = rst | rst_user;

  // Stage p0: capture the step's operands.
  always_ff @(posedge clk) begin
    if (any_rst) vld_p0 <= 1'b0;
    else         vld_p0 <= step_in;
  end

  always_ff @(posedge clk) begin
    if (step_in) begin
      ref_p0 <= ref_in;
      inc_p0 <= carrier_inc;
    end
  end

  // Stage p1: carrier advance, compare and write gating.
  pwm_tri_carrier #(
    .CNT_W        (CNT_W),
    .CARRIER_PEAK (CARRIER_PEAK)
  ) u_carrier (
    .clk          (clk),
    .rst          (any_rst),
    .advance      (vld_p0),
    .inc          (inc_p0),
    .carrier_next (carrier_next),
    .reflect      (reflect)
  );

  assign ref_clamped = clamp_ref(ref_p0);

`ifdef PWM_FIFO_WRITER_REGULAR_SAMPLE_EN
  ext_t ref_hold;

  // The reflect step itself already compares against the freshly latched value.
  always_ff @(posedge clk) begin
    if (any_rst)               ref_hold <= '0;
    else if (vld_p0 & reflect) ref_hold <= ref_clamped;
  end

  assign cmp_ref = reflect ? ref_clamped : ref_hold;
`else
  assign cmp_ref = ref_clamped;
`endif

  assign cmp_bit = cmp_ref > carrier_next;
  assign wr_ok   = !full && ({1'b0, usedw} < USEDW_LIMIT);

  // Stage p2: registered FIFO interface, FSM and priming.
  always_ff @(posedge clk) begin
    if (any_rst) begin
      state     <= ST_IDLE;
      prime_cnt <= '0;
      wr_en     <= 1'b0;
      pwm_bit   <= 1'b0;
      rd_start  <= 1'b0;
      primed    <= 1'b0;
      if (rst) overflow_err <= 1'b0;
    end else begin
      wr_en    <= vld_p0 & wr_ok;
      pwm_bit  <= vld_p0 & cmp_bit;
      rd_start <= 1'b0;
      if (vld_p0 & ~wr_ok) overflow_err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (step_in) state <= ST_PRIME;
        end
        ST_PRIME: begin
          if (vld_p0 & wr_ok) begin
            prime_cnt <= prime_cnt + 4'd1;
            if (prime_cnt == PRIME_LAST) begin
              state    <= ST_RUN;
              rd_start <= 1'b1;
              primed   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
